// File: rtl/fb_pixel_writer.sv
// Packs 8-bit gray pixels four per word and writes them to a framebuffer over a simple bus.
// Write is registered one cycle after the lane-3 pixel; pixel intake pauses while a write is outstanding.
module fb_pixel_writer #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] FB_BASE_ADDR = 32'hD000_0000,
  parameter int                    FB_WORDS     = 1024
) (
  input  logic                  ahb_clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [7:0]            pix_data,
  input  logic                  pix_sof,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_wen,
  output logic                  bus_ren,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [3:0]            bus_strobe,
  input  logic                  bus_request_stall,
  input  logic                  bus_error,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  err_sticky
);

  localparam int IDX_W = (FB_WORDS > 1) ? $clog2(FB_WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FB_WORDS - 1);

  typedef enum logic {FILL, WRITE} state_t;

  state_t                state;
  logic [1:0]            lane_cnt;
  logic [IDX_W-1:0]      word_idx;
  logic [31:0]           pack;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] next_addr;

  // Gated by rst so the handshake is quiet while reset is held, yet follows en right after release.
  assign pix_ready  = !rst && (state == FILL) && en;
  assign accept     = pix_valid && pix_ready;
  assign next_addr  = FB_BASE_ADDR + ADDR_WIDTH'({word_idx, 2'b00});
  assign bus_ren    = 1'b0;
  assign bus_strobe = bus_wen ? 4'hF : 4'h0;
  assign busy       = (state == WRITE) || (lane_cnt != 2'd0);

  always_ff @(posedge ahb_clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      lane_cnt   <= 2'd0;
      word_idx   <= '0;
      pack       <= 32'h0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_wen    <= 1'b0;
      frame_done <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            if (pix_sof) begin
              // Start of frame wins over any half-built word.
              pack     <= {24'h0, pix_data};
              lane_cnt <= 2'd1;
              word_idx <= '0;
            end else begin
              pack[{lane_cnt, 3'b000} +: 8] <= pix_data;
              lane_cnt                      <= lane_cnt + 2'd1;
              if (lane_cnt == 2'd3) begin
                state     <= WRITE;
                bus_wen   <= 1'b1;
                bus_wdata <= DATA_WIDTH'({pix_data, pack[23:0]});
                bus_addr  <= next_addr;
              end
            end
          end
        end
        WRITE: begin
          if (!bus_request_stall) begin
            state    <= FILL;
            bus_wen  <= 1'b0;
            lane_cnt <= 2'd0;
            if (bus_error) err_sticky <= 1'b1;
            if (word_idx == IDX_LAST) begin
              word_idx   <= '0;
              frame_done <= 1'b1;
            end else begin
              word_idx <= word_idx + 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer with a write scoreboard filled from a pixel-packing model.
module tb_fb_pixel_writer;

  localparam logic [31:0] BASE  = 32'hD000_0000;
  localparam int          WORDS = 1024;

  logic        ahb_clk = 1'b0;
  logic        rst, en, pix_valid, pix_ready, pix_sof;
  logic [7:0]  pix_data;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_wen, bus_ren, bus_request_stall, bus_error;
  logic [3:0]  bus_strobe;
  logic        frame_done, busy, err_sticky;

  fb_pixel_writer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .FB_BASE_ADDR(BASE), .FB_WORDS(WORDS)
  ) dut (
    .ahb_clk(ahb_clk), .rst(rst), .en(en), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_sof(pix_sof), .bus_addr(bus_addr), .bus_wen(bus_wen),
    .bus_ren(bus_ren), .bus_wdata(bus_wdata), .bus_strobe(bus_strobe),
    .bus_request_stall(bus_request_stall), .bus_error(bus_error), .frame_done(frame_done),
    .busy(busy), .err_sticky(err_sticky)
  );

  always #5 ahb_clk = ~ahb_clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_writes = 0;
  int          fd_count = 0;
  logic        fd_expect = 1'b0;
  int          m_lane = 0;
  int          m_idx = 0;
  logic [31:0] m_pack = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ahb_clk);
    #1;
  endtask

  // Drive one pixel, wait for the handshake, and advance the packing model on acceptance.
  task automatic send_pix(input logic [7:0] d, input logic s);
    int t = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = s;
    @(negedge ahb_clk);
    while (!pix_ready && t < 50) begin
      @(negedge ahb_clk);
      t++;
    end
    if (!pix_ready) chk("pix_accept_timeout", {31'h0, pix_ready}, 32'h1);
    else begin
      @(posedge ahb_clk);
      if (s) begin
        m_pack      = 32'h0;
        m_pack[7:0] = d;
        m_lane      = 1;
        m_idx       = 0;
      end else begin
        m_pack[m_lane*8 +: 8] = d;
        if (m_lane == 3) begin
          sb.push_back('{addr: BASE + 32'(m_idx * 4), data: m_pack, last: (m_idx == WORDS - 1)});
          m_idx  = (m_idx + 1) % WORDS;
          m_lane = 0;
        end else m_lane++;
      end
      #1;
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] b, input logic s);
    for (int k = 0; k < 4; k++) send_pix(b + 8'(k), s && (k == 0));
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || bus_wen) && t < 200) begin
      @(negedge ahb_clk);
      t++;
    end
    if (sb.size() != 0 || bus_wen) chk("drain_timeout", 32'(sb.size()), 32'h0);
  endtask

  // Completion monitor: pops the scoreboard on each unstalled write and checks the frame_done pulse.
  always @(negedge ahb_clk) begin
    if (!rst) begin
      if (fd_expect || frame_done) chk("frame_done", {31'h0, frame_done}, {31'h0, fd_expect});
      if (frame_done) fd_count++;
      fd_expect = 1'b0;
      if (bus_wen && !bus_request_stall) begin
        exp_t e;
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_bad++;
          $error("FAIL unexpected_write: observed addr 0x%08h data 0x%08h expected none", bus_addr, bus_wdata);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("wr_addr", bus_addr, e.addr);
          chk("wr_data", bus_wdata, e.data);
          chk("wr_strobe", {28'h0, bus_strobe}, 32'hF);
          fd_expect = e.last;
          n_writes++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, f0;
    rst = 1'b1; en = 1'b1; pix_valid = 1'b0; pix_data = 8'h0; pix_sof = 1'b0;
    bus_request_stall = 1'b0; bus_error = 1'b0;

    // Reset state, with en already high.
    repeat (3) @(posedge ahb_clk);
    @(negedge ahb_clk);
    chk("rst_pix_ready", {31'h0, pix_ready}, 32'h0);
    chk("rst_bus_wen", {31'h0, bus_wen}, 32'h0);
    chk("rst_bus_ren", {31'h0, bus_ren}, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_bus_strobe", {28'h0, bus_strobe}, 32'h0);
    chk("rst_frame_done", {31'h0, frame_done}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_err_sticky", {31'h0, err_sticky}, 32'h0);
    step();
    rst = 1'b0;
    @(negedge ahb_clk);
    chk("ready_after_rst", {31'h0, pix_ready}, 32'h1);
    en = 1'b0;
    #1 chk("ready_en_low", {31'h0, pix_ready}, 32'h0);
    en = 1'b1;
    step();

    // Basic word, no stall.
    send_pix(8'h11, 1'b1); send_pix(8'h22, 1'b0); send_pix(8'h33, 1'b0); send_pix(8'h44, 1'b0);
    @(negedge ahb_clk);
    chk("basic_wen", {31'h0, bus_wen}, 32'h1);
    chk("basic_addr", bus_addr, 32'hD000_0000);
    chk("basic_wdata", bus_wdata, 32'h4433_2211);
    chk("basic_strobe", {28'h0, bus_strobe}, 32'hF);
    chk("basic_ready_low", {31'h0, pix_ready}, 32'h0);
    chk("basic_busy", {31'h0, busy}, 32'h1);
    step();
    @(negedge ahb_clk);
    chk("basic_ready_back", {31'h0, pix_ready}, 32'h1);
    chk("basic_wen_off", {31'h0, bus_wen}, 32'h0);
    chk("basic_strobe_off", {28'h0, bus_strobe}, 32'h0);
    chk("basic_idle", {31'h0, busy}, 32'h0);
    drain();

    // Stalled write holds for 3 extra cycles.
    step();
    bus_request_stall = 1'b1;
    send_pix(8'h55, 1'b1); send_pix(8'h66, 1'b0); send_pix(8'h77, 1'b0); send_pix(8'h88, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge ahb_clk);
      chk("stall_wen", {31'h0, bus_wen}, 32'h1);
      chk("stall_addr", bus_addr, 32'hD000_0000);
      chk("stall_wdata", bus_wdata, 32'h8877_6655);
      chk("stall_ready", {31'h0, pix_ready}, 32'h0);
      step();
    end
    bus_request_stall = 1'b0;
    @(negedge ahb_clk);
    chk("stall_wen_last", {31'h0, bus_wen}, 32'h1);
    step();
    @(negedge ahb_clk);
    chk("stall_wen_off", {31'h0, bus_wen}, 32'h0);
    chk("stall_ready_back", {31'h0, pix_ready}, 32'h1);
    drain();

    // Partial word discarded by a new start of frame.
    step();
    w0 = n_writes;
    send_pix(8'h01, 1'b0); send_pix(8'h02, 1'b0);
    @(negedge ahb_clk);
    chk("partial_busy", {31'h0, busy}, 32'h1);
    chk("partial_no_wen", {31'h0, bus_wen}, 32'h0);
    step();
    send_pix(8'hAA, 1'b1); send_pix(8'hBB, 1'b0); send_pix(8'hCC, 1'b0); send_pix(8'hDD, 1'b0);
    @(negedge ahb_clk);
    chk("sof_addr", bus_addr, 32'hD000_0000);
    chk("sof_wdata", bus_wdata, 32'hDDCC_BBAA);
    drain();
    chk("sof_write_count", 32'(n_writes - w0), 32'h1);

    // Error on word 5 is sticky; word 6 still lands at +0x18.
    step();
    for (int w = 1; w < 5; w++) send_word(8'(w * 16), 1'b0);
    drain();
    chk("err_before", {31'h0, err_sticky}, 32'h0);
    bus_error = 1'b1;
    step();
    send_word(8'h50, 1'b0);
    drain();
    bus_error = 1'b0;
    step();
    chk("err_set", {31'h0, err_sticky}, 32'h1);
    send_word(8'h60, 1'b0);
    @(negedge ahb_clk);
    chk("word6_addr", bus_addr, 32'hD000_0018);
    drain();
    chk("err_persist", {31'h0, err_sticky}, 32'h1);

    // Reset in the middle of a stalled write.
    step();
    bus_request_stall = 1'b1;
    send_word(8'hC0, 1'b1);
    @(negedge ahb_clk);
    chk("midrst_wen_before", {31'h0, bus_wen}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_wen_drop", {31'h0, bus_wen}, 32'h0);
    chk("midrst_err_clear", {31'h0, err_sticky}, 32'h0);
    chk("midrst_ready", {31'h0, pix_ready}, 32'h0);
    sb.delete();
    m_idx = 0; m_lane = 0; m_pack = 32'h0;
    step();
    bus_request_stall = 1'b0;
    step();
    rst = 1'b0;
    step();
    send_word(8'h70, 1'b1);
    @(negedge ahb_clk);
    chk("restart_addr", bus_addr, 32'hD000_0000);
    drain();
    chk("restart_err", {31'h0, err_sticky}, 32'h0);

    // Full frame, then wrap to the base address.
    step();
    w0 = n_writes;
    f0 = fd_count;
    for (int i = 0; i < 4 * WORDS; i++) send_pix(8'(i * 37 + 5), i == 0);
    drain();
    step();
    step();
    chk("frame_writes", 32'(n_writes - w0), 32'(WORDS));
    chk("frame_done_count", 32'(fd_count - f0), 32'h1);
    send_word(8'hE0, 1'b0);
    @(negedge ahb_clk);
    chk("wrap_addr", bus_addr, 32'hD000_0000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_pixel_writer.md
FB_PIXEL_WRITER -- requirements
Module: fb_pixel_writer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, bus address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, bus data width; only 32 is supported.
REQ-003 The block SHALL have parameter FB_BASE_ADDR, default 32'hD000_0000, framebuffer byte base address.
REQ-004 The block SHALL have parameter FB_WORDS, default 1024, words per frame (64x64 8-bit gray, 4 pixels/word).
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset, with these ports:
- ahb_clk  in  1  sole clock
- rst  in  1  asynchronous active-high reset
- en  in  1  enable pixel acceptance
- pix_valid  in  1  pixel present
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- pix_data  in  8  gray pixel value
- pix_sof  in  1  marks pixel 0 of a frame
- bus_addr  out  ADDR_WIDTH  write byte address
- bus_wen  out  1  write request
- bus_ren  out  1  read request, tied 0
- bus_wdata  out  DATA_WIDTH  write data
- bus_strobe  out  4  byte enables, 4'hF whenever bus_wen=1, else 0
- bus_request_stall  in  1  responder not ready; transfer holds
- bus_error  in  1  responder error, sampled at completion
- frame_done  out  1  one-cycle pulse after last word of a frame completes
- busy  out  1  high in WRITE state or when a partial word is held
- err_sticky  out  1  set by any errored write, cleared only by reset

Function
REQ-006 FSM states SHALL be FILL and WRITE.
REQ-007 FILL SHALL drive pix_ready = en; every accepted pixel is placed in lane lane_cnt of the pack register (lane 0 = bits [7:0], lane 3 = bits [31:24]); lane_cnt increments mod 4.
REQ-008 An accepted pixel with pix_sof=1 SHALL be written to lane 0, discard any partial lanes, reset word_idx to 0, and set lane_cnt to 1.
REQ-009 Acceptance of the lane-3 pixel in cycle N SHALL move to WRITE and present, registered in cycle N+1: bus_wen=1, bus_wdata = packed word, bus_addr = FB_BASE_ADDR + 4*word_idx.
REQ-010 WRITE SHALL drive pix_ready=0 and hold bus_addr, bus_wdata, bus_wen and bus_strobe stable while bus_request_stall=1, for any number of cycles.
REQ-011 A transfer SHALL complete on the first WRITE cycle with bus_request_stall=0. In the next cycle: bus_wen=0, state=FILL, lane_cnt=0, and word_idx increments.
REQ-012 When bus_error=1 at completion, err_sticky SHALL be set; word_idx still advances and no retry is made.
REQ-013 Completion with word_idx = FB_WORDS-1 SHALL pulse frame_done for exactly one cycle (the cycle after completion) and wrap word_idx to 0.
REQ-014 word_idx SHALL be log2(FB_WORDS) bits; the address SHALL be computed as FB_BASE_ADDR + {word_idx,2'b00}, zero-extended to ADDR_WIDTH.
REQ-015 en low SHALL only block new pixel acceptance; an in-flight WRITE completes normally, and partial lanes are retained.
REQ-016 pix_sof SHALL be ignored unless the pixel is accepted; pixels are never accepted in WRITE.
REQ-017 Peak throughput SHALL be one word per 5 cycles with no stall (4 FILL + 1 WRITE).

Reset
REQ-018 While rst=1, all outputs SHALL be 0: pix_ready, bus_wen, bus_ren, bus_addr, bus_wdata, bus_strobe, frame_done, busy, err_sticky. State SHALL be FILL, and lane_cnt, word_idx and the pack register SHALL be 0.
REQ-019 Reset asserted during WRITE SHALL drop bus_wen asynchronously; the in-flight word is lost.
REQ-020 After rst deasserts, pix_ready SHALL follow en from the first clock edge.

Verification
REQ-021 Pixels 0x11,0x22,0x33,0x44, sof on the first, no stall -> one write: addr 0xD000_0000, wdata 0x4433_2211, strobe 4'hF; pix_ready low for exactly 1 cycle.
REQ-022 Same stimulus with request_stall=1 for 3 cycles -> bus_wen high 4 cycles with addr/wdata constant; the next pixel is accepted only after completion.
REQ-023 4096 pixels from sof, no stall -> 1024 writes at addresses 0xD000_0000..0xD000_0FFC in order; frame_done pulses once after the last; the next write goes to 0xD000_0000.
REQ-024 Two pixels, then sof pixel 0xAA plus 3 more pixels -> a single write to 0xD000_0000 with bits [7:0]=0xAA; the first two pixels never appear on the bus.
REQ-025 bus_error=1 at completion of word 5 -> err_sticky=1 persists, and word 6 is still written to 0xD000_0018.
REQ-026 rst pulsed mid-WRITE -> bus_wen=0 immediately; after release, a sof frame restarts at 0xD000_0000 with err_sticky=0.
